// File: rtl/order_encoder.sv
// Serializes one accepted order into a 32-byte wire message, emitted as four
// 64-bit Avalon-ST beats with a per-order sequence number and XOR checksum.
module order_encoder #(
    parameter logic [7:0]  C_MSG_TYPE = 8'h4F,
    parameter logic [31:0] C_SEQ_INIT = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        order_valid,
    output logic        order_ready,
    input  logic        order_side,
    input  logic [63:0] order_symbol,
    input  logic [63:0] order_price,
    input  logic [31:0] order_volume,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_startofpacket,
    output logic        out_endofpacket,
    output logic [63:0] out_data,
    output logic [2:0]  out_empty,
    output logic        out_error,
    output logic [31:0] seq_next,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_B0   = 3'd1,
        S_B1   = 3'd2,
        S_B2   = 3'd3,
        S_B3   = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        accept;
    logic [31:0] hdr_word;
    logic [31:0] csum;
    logic [63:0] msg_b0;
    logic [63:0] msg_b1;
    logic [63:0] msg_b2;
    logic [63:0] msg_b3;

    // Both ports use valid/ready: a transfer happens on a rising edge where
    // valid && ready; a producer holding valid keeps its payload stable until then.
    assign order_ready = (state == S_IDLE) || ((state == S_B3) && out_ready);
    assign accept      = order_valid && order_ready;

    assign hdr_word = {16'd32, C_MSG_TYPE, 7'd0, order_side};
    assign csum     = hdr_word ^ seq_next
                    ^ order_symbol[63:32] ^ order_symbol[31:0]
                    ^ order_price[63:32]  ^ order_price[31:0]
                    ^ order_volume;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept)    state_nxt = S_B0;
            S_B0:   if (out_ready) state_nxt = S_B1;
            S_B1:   if (out_ready) state_nxt = S_B2;
            S_B2:   if (out_ready) state_nxt = S_B3;
            S_B3:   if (out_ready) state_nxt = accept ? S_B0 : S_IDLE;
            default:               state_nxt = S_IDLE;
        endcase
    end

    // The message register is only rewritten on accept, so beats stay stable
    // under backpressure without any extra hold logic.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            msg_b0   <= 64'd0;
            msg_b1   <= 64'd0;
            msg_b2   <= 64'd0;
            msg_b3   <= 64'd0;
            seq_next <= C_SEQ_INIT;
        end else if (accept) begin
            msg_b0   <= {hdr_word, seq_next};
            msg_b1   <= order_symbol;
            msg_b2   <= order_price;
            msg_b3   <= {order_volume, csum};
            seq_next <= seq_next + 32'd1;
        end
    end

    always_comb begin
        out_data = 64'd0;
        case (state)
            S_B0:    out_data = msg_b0;
            S_B1:    out_data = msg_b1;
            S_B2:    out_data = msg_b2;
            S_B3:    out_data = msg_b3;
            default: out_data = 64'd0;
        endcase
    end

    assign out_valid         = (state != S_IDLE);
    assign out_startofpacket = (state == S_B0);
    assign out_endofpacket   = (state == S_B3);
    assign out_empty         = 3'd0;
    assign out_error         = 1'b0;
    assign state_dbg         = state;

endmodule
